// File: rtl/fe_simple_rx_burst.sv
// RX burst packer: timestamps a continuous ADC stream, packs fixed-size bursts into
// 64-bit ring-RAM words and emits one {ts, samples-1, words-1} descriptor per burst.
module fe_simple_rx_burst #(
    parameter int TIMESTAMP_BITS  = 48,
    parameter int RAM_ADDR_WIDTH  = 18,
    parameter int DATA_BITS       = 3,
    parameter int DATA_WIDTH      = 8 << DATA_BITS,
    parameter int SAMPLES_WIDTH   = 17,
    parameter int WORD_ADDR_WIDTH = RAM_ADDR_WIDTH - DATA_BITS,
    parameter int DESCR_WIDTH     = TIMESTAMP_BITS + SAMPLES_WIDTH + WORD_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      adc_data,
    input  logic                       adc_valid,
    input  logic                       adc_sync,
    input  logic                       cfg_enable,
    input  logic                       cfg_format,
    input  logic                       cfg_swap,
    input  logic [SAMPLES_WIDTH-1:0]   cfg_burst_samples,
    input  logic [WORD_ADDR_WIDTH-1:0] ram_rd_ptr,
    output logic [WORD_ADDR_WIDTH-1:0] m_fifo_awaddr,
    output logic [DATA_WIDTH-1:0]      m_fifo_wdata,
    output logic                       m_fifo_wvalid,
    input  logic                       m_fifo_wready,
    output logic                       m_descr_valid,
    input  logic                       m_descr_ready,
    output logic [DESCR_WIDTH-1:0]     m_descr_data,
    output logic [TIMESTAMP_BITS-1:0]  rx_timer,
    output logic [31:0]                overflows,
    output logic                       sig_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DROP, S_DESCR} state_t;

    state_t                     state_q, state_d;
    logic [TIMESTAMP_BITS-1:0]  timer_q, timer_d;
    logic [TIMESTAMP_BITS-1:0]  ts_q, ts_d;
    logic [WORD_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WORD_ADDR_WIDTH-1:0] base_q, base_d;
    logic [SAMPLES_WIDTH-1:0]   scnt_q, scnt_d;
    logic [SAMPLES_WIDTH-1:0]   nm1_q, nm1_d;
    logic [WORD_ADDR_WIDTH-1:0] wm1_q, wm1_d;
    logic                       fmt_q, fmt_d;
    logic                       swap_q, swap_d;
    logic [31:0]                lo_q, lo_d;
    logic                       wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       wlast_q, wlast_d;
    logic                       pend_q, pend_d;
    logic                       pend_ack_q, pend_ack_d;
    logic [DESCR_WIDTH-1:0]     pend_data_q, pend_data_d;
    logic                       descr_valid_q, descr_valid_d;
    logic [DESCR_WIDTH-1:0]     descr_data_q, descr_data_d;
    logic [31:0]                ovf_cnt_q, ovf_cnt_d;
    logic                       ovf_pulse_q, ovf_pulse_d;

    logic                       hs;
    logic                       start_req;
    logic                       start_drop;
    logic [WORD_ADDR_WIDTH-1:0] free_words;
    logic [SAMPLES_WIDTH:0]     need_words;
    logic [WORD_ADDR_WIDTH-1:0] wm1_start;
    logic                       fmt_e, swap_e, is_last, word_done, take;
    logic [SAMPLES_WIDTH-1:0]   nm1_e, idx_e;
    logic [WORD_ADDR_WIDTH-1:0] wm1_e;
    logic [TIMESTAMP_BITS-1:0]  ts_e;
    logic [DATA_WIDTH-1:0]      word_val;

    assign hs        = wvalid_q && m_fifo_wready;
    assign start_req = adc_valid && adc_sync && cfg_enable &&
                       (state_q == S_IDLE || state_q == S_DESCR);
    // An unaccepted word still occupies a slot even though wr_ptr has not moved yet.
    assign free_words = ram_rd_ptr - wr_ptr_q - WORD_ADDR_WIDTH'(1) - WORD_ADDR_WIDTH'(wvalid_q);
    assign need_words = cfg_format ? ({1'b0, cfg_burst_samples} + (SAMPLES_WIDTH+1)'(1))
                                   : ({1'b0, cfg_burst_samples >> 1} + (SAMPLES_WIDTH+1)'(1));
    assign wm1_start  = WORD_ADDR_WIDTH'(cfg_format ? cfg_burst_samples : (cfg_burst_samples >> 1));
    assign start_drop = (32'(free_words) < 32'(need_words)) || descr_valid_q;

    // Effective burst parameters: live config on the starting sample, latched afterwards.
    assign fmt_e   = start_req ? cfg_format        : fmt_q;
    assign swap_e  = start_req ? cfg_swap          : swap_q;
    assign nm1_e   = start_req ? cfg_burst_samples : nm1_q;
    assign wm1_e   = start_req ? wm1_start         : wm1_q;
    assign ts_e    = start_req ? timer_q           : ts_q;
    assign idx_e   = start_req ? '0                : scnt_q;
    assign is_last = (idx_e == nm1_e);

    always_comb begin
        word_done = 1'b0;
        word_val  = '0;
        if (fmt_e) begin
            word_done = 1'b1;
            word_val  = swap_e ? {adc_data[31:0], adc_data[63:32]} : adc_data;
        end else if (idx_e[0]) begin
            word_done = 1'b1;
            word_val  = {adc_data[31:0], lo_q};
        end else begin
            word_done = is_last;
            word_val  = {32'd0, adc_data[31:0]};
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ts_d          = ts_q;
        wr_ptr_d      = wr_ptr_q + WORD_ADDR_WIDTH'(hs);
        base_d        = base_q;
        scnt_d        = scnt_q;
        nm1_d         = nm1_q;
        wm1_d         = wm1_q;
        fmt_d         = fmt_q;
        swap_d        = swap_q;
        lo_d          = lo_q;
        wvalid_d      = wvalid_q && !m_fifo_wready;
        wdata_d       = wdata_q;
        wlast_d       = wlast_q;
        pend_d        = pend_q;
        pend_ack_d    = pend_ack_q;
        pend_data_d   = pend_data_q;
        descr_valid_d = descr_valid_q && !m_descr_ready;
        descr_data_d  = descr_data_q;
        ovf_cnt_d     = ovf_cnt_q;
        ovf_pulse_d   = 1'b0;
        take          = 1'b0;

        if (!adc_sync) begin
            timer_d = '0;
        end else if (adc_valid) begin
            timer_d = timer_q + TIMESTAMP_BITS'(1);
        end

        // A finished burst's descriptor waits for its last word and for the output slot.
        if (pend_q && (pend_ack_q || (hs && wlast_q)) && (!descr_valid_q || m_descr_ready)) begin
            descr_valid_d = 1'b1;
            descr_data_d  = pend_data_q;
            pend_d        = 1'b0;
            pend_ack_d    = 1'b0;
        end else if (pend_q && hs && wlast_q) begin
            pend_ack_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DESCR: begin
                if (state_q == S_DESCR && !pend_q && !descr_valid_q) begin
                    state_d = S_IDLE;
                end
                if (start_req) begin
                    fmt_d  = cfg_format;
                    swap_d = cfg_swap;
                    nm1_d  = cfg_burst_samples;
                    wm1_d  = wm1_start;
                    ts_d   = timer_q;
                    base_d = wr_ptr_q + WORD_ADDR_WIDTH'(wvalid_q);
                    if (start_drop) begin
                        ovf_pulse_d = 1'b1;
                        ovf_cnt_d   = ovf_cnt_q + 32'd1;
                        scnt_d      = SAMPLES_WIDTH'(1);
                        state_d     = (cfg_burst_samples == '0) ? S_IDLE : S_DROP;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (!adc_sync) begin
                    ovf_pulse_d = 1'b1;
                    ovf_cnt_d   = ovf_cnt_q + 32'd1;
                    state_d     = S_IDLE;
                    // A pending last word of the previous burst is not ours to discard.
                    if (!(wvalid_q && wlast_q)) begin
                        wvalid_d = 1'b0;
                        wr_ptr_d = base_q;
                    end
                end else if (adc_valid) begin
                    take = 1'b1;
                end
            end
            S_DROP: begin
                if (!adc_sync) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    if (scnt_q == nm1_q) begin
                        state_d = S_IDLE;
                    end else begin
                        scnt_d = scnt_q + SAMPLES_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            if (!fmt_e && !idx_e[0]) begin
                lo_d = adc_data[31:0];
            end
            if (word_done && wvalid_q && !m_fifo_wready) begin
                ovf_pulse_d = 1'b1;
                ovf_cnt_d   = ovf_cnt_q + 32'd1;
                if (!wlast_q) begin
                    wvalid_d = 1'b0;
                    wr_ptr_d = base_q;
                end
                scnt_d  = idx_e + SAMPLES_WIDTH'(1);
                state_d = is_last ? S_IDLE : S_DROP;
            end else begin
                if (word_done) begin
                    wvalid_d = 1'b1;
                    wdata_d  = word_val;
                    wlast_d  = is_last;
                end
                if (is_last) begin
                    state_d     = S_DESCR;
                    pend_d      = 1'b1;
                    pend_ack_d  = 1'b0;
                    pend_data_d = {ts_e, nm1_e, wm1_e};
                end else begin
                    state_d = S_BURST;
                    scnt_d  = idx_e + SAMPLES_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            ts_q          <= '0;
            wr_ptr_q      <= '0;
            base_q        <= '0;
            scnt_q        <= '0;
            nm1_q         <= '0;
            wm1_q         <= '0;
            fmt_q         <= 1'b0;
            swap_q        <= 1'b0;
            lo_q          <= '0;
            wvalid_q      <= 1'b0;
            wdata_q       <= '0;
            wlast_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_ack_q    <= 1'b0;
            pend_data_q   <= '0;
            descr_valid_q <= 1'b0;
            descr_data_q  <= '0;
            ovf_cnt_q     <= '0;
            ovf_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ts_q          <= ts_d;
            wr_ptr_q      <= wr_ptr_d;
            base_q        <= base_d;
            scnt_q        <= scnt_d;
            nm1_q         <= nm1_d;
            wm1_q         <= wm1_d;
            fmt_q         <= fmt_d;
            swap_q        <= swap_d;
            lo_q          <= lo_d;
            wvalid_q      <= wvalid_d;
            wdata_q       <= wdata_d;
            wlast_q       <= wlast_d;
            pend_q        <= pend_d;
            pend_ack_q    <= pend_ack_d;
            pend_data_q   <= pend_data_d;
            descr_valid_q <= descr_valid_d;
            descr_data_q  <= descr_data_d;
            ovf_cnt_q     <= ovf_cnt_d;
            ovf_pulse_q   <= ovf_pulse_d;
        end
    end

    assign m_fifo_awaddr = wr_ptr_q;
    assign m_fifo_wdata  = wdata_q;
    assign m_fifo_wvalid = wvalid_q;
    assign m_descr_valid = descr_valid_q;
    assign m_descr_data  = descr_data_q;
    assign rx_timer      = timer_q;
    assign overflows     = ovf_cnt_q;
    assign sig_overflow  = ovf_pulse_q;

endmodule

// File: tb/tb_fe_simple_rx_burst.sv
// Directed bench for fe_simple_rx_burst: packing formats, descriptors, drops,
// stalls, sync abort and asynchronous reset.
module tb_fe_simple_rx_burst;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  adc_data;
    logic         adc_valid;
    logic         adc_sync;
    logic         cfg_enable;
    logic         cfg_format;
    logic         cfg_swap;
    logic [16:0]  cfg_burst_samples;
    logic [14:0]  ram_rd_ptr;
    logic [14:0]  m_fifo_awaddr;
    logic [63:0]  m_fifo_wdata;
    logic         m_fifo_wvalid;
    logic         m_fifo_wready;
    logic         m_descr_valid;
    logic         m_descr_ready;
    logic [79:0]  m_descr_data;
    logic [47:0]  rx_timer;
    logic [31:0]  overflows;
    logic         sig_overflow;

    int total = 0;
    int bad   = 0;

    fe_simple_rx_burst dut (
        .clk               (clk),
        .rst               (rst),
        .adc_data          (adc_data),
        .adc_valid         (adc_valid),
        .adc_sync          (adc_sync),
        .cfg_enable        (cfg_enable),
        .cfg_format        (cfg_format),
        .cfg_swap          (cfg_swap),
        .cfg_burst_samples (cfg_burst_samples),
        .ram_rd_ptr        (ram_rd_ptr),
        .m_fifo_awaddr     (m_fifo_awaddr),
        .m_fifo_wdata      (m_fifo_wdata),
        .m_fifo_wvalid     (m_fifo_wvalid),
        .m_fifo_wready     (m_fifo_wready),
        .m_descr_valid     (m_descr_valid),
        .m_descr_ready     (m_descr_ready),
        .m_descr_data      (m_descr_data),
        .rx_timer          (rx_timer),
        .overflows         (overflows),
        .sig_overflow      (sig_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [63:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    function automatic logic [79:0] descr(input int ts, input int n1, input int w1);
        return {48'(ts), 17'(n1), 15'(w1)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        adc_data          = '0;
        adc_valid         = 1'b0;
        adc_sync          = 1'b0;
        cfg_enable        = 1'b0;
        cfg_format        = 1'b0;
        cfg_swap          = 1'b0;
        cfg_burst_samples = '0;
        ram_rd_ptr        = '0;
        m_fifo_wready     = 1'b1;
        m_descr_ready     = 1'b0;
        repeat (3) tick();
        chk("rst_wvalid", 128'(m_fifo_wvalid), 128'(0));
        chk("rst_awaddr", 128'(m_fifo_awaddr), 128'(0));
        chk("rst_wdata", 128'(m_fifo_wdata), 128'(0));
        chk("rst_dvalid", 128'(m_descr_valid), 128'(0));
        chk("rst_ddata", 128'(m_descr_data), 128'(0));
        chk("rst_timer", 128'(rx_timer), 128'(0));
        chk("rst_ovf", 128'(overflows), 128'(0));
        chk("rst_sigovf", 128'(sig_overflow), 128'(0));

        rst      = 1'b1;
        adc_sync = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) sample(64'h0);
        chk("timer10", 128'(rx_timer), 128'(10));
        chk("no_burst_disabled", 128'(m_fifo_wvalid), 128'(0));

        // Format 0, N=4
        cfg_enable = 1'b1; cfg_format = 1'b0; cfg_burst_samples = 17'd3;
        sample(64'hDEAD0000_AAAA0001);
        chk("f0_a_wvalid", 128'(m_fifo_wvalid), 128'(0));
        sample(64'hDEAD0000_BBBB0002);
        chk("f0_b_wvalid", 128'(m_fifo_wvalid), 128'(1));
        chk("f0_b_wdata", 128'(m_fifo_wdata), 128'(64'hBBBB0002_AAAA0001));
        chk("f0_b_addr", 128'(m_fifo_awaddr), 128'(0));
        sample(64'hDEAD0000_CCCC0003);
        chk("f0_c_wvalid", 128'(m_fifo_wvalid), 128'(0));
        chk("f0_c_addr", 128'(m_fifo_awaddr), 128'(1));
        sample(64'hDEAD0000_DDDD0004);
        chk("f0_d_wvalid", 128'(m_fifo_wvalid), 128'(1));
        chk("f0_d_wdata", 128'(m_fifo_wdata), 128'(64'hDDDD0004_CCCC0003));
        chk("f0_d_addr", 128'(m_fifo_awaddr), 128'(1));
        chk("f0_no_early_descr", 128'(m_descr_valid), 128'(0));
        tick();
        chk("f0_dvalid", 128'(m_descr_valid), 128'(1));
        chk("f0_ddata", 128'(m_descr_data), 128'(descr(10, 3, 1)));
        chk("f0_addr_end", 128'(m_fifo_awaddr), 128'(2));
        tick();
        chk("f0_dvalid_hold", 128'(m_descr_valid), 128'(1));
        m_descr_ready = 1'b1;
        tick();
        chk("f0_dvalid_clr", 128'(m_descr_valid), 128'(0));
        chk("timer14", 128'(rx_timer), 128'(14));

        // Format 1 with swap, N=2
        cfg_format = 1'b1; cfg_swap = 1'b1; cfg_burst_samples = 17'd1;
        sample(64'h11112222_33334444);
        chk("f1_w0_data", 128'(m_fifo_wdata), 128'(64'h33334444_11112222));
        chk("f1_w0_valid", 128'(m_fifo_wvalid), 128'(1));
        chk("f1_w0_addr", 128'(m_fifo_awaddr), 128'(2));
        sample(64'h55556666_77778888);
        chk("f1_w1_data", 128'(m_fifo_wdata), 128'(64'h77778888_55556666));
        chk("f1_w1_addr", 128'(m_fifo_awaddr), 128'(3));
        tick();
        chk("f1_ddata", 128'(m_descr_data), 128'(descr(14, 1, 1)));
        chk("f1_dvalid", 128'(m_descr_valid), 128'(1));
        tick();
        chk("f1_dvalid_clr", 128'(m_descr_valid), 128'(0));
        chk("f1_addr_end", 128'(m_fifo_awaddr), 128'(4));

        // Format 0, odd N=3
        cfg_format = 1'b0; cfg_swap = 1'b0; cfg_burst_samples = 17'd2;
        sample(64'h12345678_EEEE0005);
        sample(64'h12345678_FFFF0006);
        chk("odd_w0_data", 128'(m_fifo_wdata), 128'(64'hFFFF0006_EEEE0005));
        chk("odd_w0_addr", 128'(m_fifo_awaddr), 128'(4));
        sample(64'h12345678_99990007);
        chk("odd_w1_data", 128'(m_fifo_wdata), 128'(64'h00000000_99990007));
        chk("odd_w1_addr", 128'(m_fifo_awaddr), 128'(5));
        tick();
        chk("odd_ddata", 128'(m_descr_data), 128'(descr(16, 2, 1)));
        chk("odd_addr_end", 128'(m_fifo_awaddr), 128'(6));
        tick();

        // free=1, N=8 format 1: whole burst dropped
        ram_rd_ptr = 15'd8; cfg_format = 1'b1; cfg_burst_samples = 17'd7;
        sample(64'h0);
        chk("drop_sig", 128'(sig_overflow), 128'(1));
        chk("drop_ovf", 128'(overflows), 128'(1));
        chk("drop_wvalid", 128'(m_fifo_wvalid), 128'(0));
        for (int i = 0; i < 6; i++) sample(64'h0);
        chk("drop_sig_once", 128'(sig_overflow), 128'(0));
        chk("drop_wvalid7", 128'(m_fifo_wvalid), 128'(0));
        chk("drop_ovf7", 128'(overflows), 128'(1));
        ram_rd_ptr = 15'd0; cfg_burst_samples = 17'd0;
        sample(64'h0);
        chk("drop_8th_nowrite", 128'(m_fifo_wvalid), 128'(0));
        sample(64'h01234567_89ABCDEF);
        chk("after_drop_wvalid", 128'(m_fifo_wvalid), 128'(1));
        chk("after_drop_wdata", 128'(m_fifo_wdata), 128'(64'h01234567_89ABCDEF));
        chk("after_drop_addr", 128'(m_fifo_awaddr), 128'(6));
        tick();
        chk("after_drop_ddata", 128'(m_descr_data), 128'(descr(27, 0, 0)));
        tick();
        chk("after_drop_addr_end", 128'(m_fifo_awaddr), 128'(7));
        chk("timer28", 128'(rx_timer), 128'(28));

        // wready stall in format 1, N=3: overflow on second sample
        m_fifo_wready = 1'b0; cfg_burst_samples = 17'd2;
        sample(64'hA0A0A0A0_B0B0B0B0);
        chk("stall_w0_valid", 128'(m_fifo_wvalid), 128'(1));
        chk("stall_w0_addr", 128'(m_fifo_awaddr), 128'(7));
        sample(64'hA1A1A1A1_B1B1B1B1);
        chk("stall_ovf_wvalid", 128'(m_fifo_wvalid), 128'(0));
        chk("stall_ovf_sig", 128'(sig_overflow), 128'(1));
        chk("stall_ovf_cnt", 128'(overflows), 128'(2));
        chk("stall_rewind", 128'(m_fifo_awaddr), 128'(7));
        sample(64'hA2A2A2A2_B2B2B2B2);
        chk("stall_sig_clr", 128'(sig_overflow), 128'(0));
        chk("stall_no_write", 128'(m_fifo_wvalid), 128'(0));
        m_fifo_wready = 1'b1;
        tick();
        tick();
        chk("stall_no_descr", 128'(m_descr_valid), 128'(0));
        chk("stall_addr", 128'(m_fifo_awaddr), 128'(7));

        // Descriptor held across next burst start
        m_descr_ready = 1'b0; cfg_format = 1'b0; cfg_burst_samples = 17'd1;
        sample(64'h0_12340001);
        sample(64'h0_56780002);
        chk("hold_wdata", 128'(m_fifo_wdata), 128'(64'h56780002_12340001));
        chk("hold_addr", 128'(m_fifo_awaddr), 128'(7));
        tick();
        chk("hold_dvalid", 128'(m_descr_valid), 128'(1));
        chk("hold_ddata", 128'(m_descr_data), 128'(descr(31, 1, 0)));
        sample(64'h0_0000AAAA);
        chk("hold_drop_sig", 128'(sig_overflow), 128'(1));
        chk("hold_drop_cnt", 128'(overflows), 128'(3));
        sample(64'h0_0000BBBB);
        tick();
        chk("hold_ddata_stable", 128'(m_descr_data), 128'(descr(31, 1, 0)));
        chk("hold_dvalid_stable", 128'(m_descr_valid), 128'(1));
        chk("hold_no_write", 128'(m_fifo_awaddr), 128'(8));
        m_descr_ready = 1'b1;
        tick();
        chk("hold_accept", 128'(m_descr_valid), 128'(0));

        // adc_sync low mid-burst aborts and rewinds
        cfg_format = 1'b1; cfg_burst_samples = 17'd3;
        sample(64'hCAFE0000_0000BEEF);
        chk("abort_w0_addr", 128'(m_fifo_awaddr), 128'(8));
        chk("abort_w0_valid", 128'(m_fifo_wvalid), 128'(1));
        tick();
        chk("abort_adv", 128'(m_fifo_awaddr), 128'(9));
        adc_sync = 1'b0;
        tick();
        chk("abort_rewind", 128'(m_fifo_awaddr), 128'(8));
        chk("abort_ovf", 128'(overflows), 128'(4));
        chk("abort_sig", 128'(sig_overflow), 128'(1));
        chk("abort_timer", 128'(rx_timer), 128'(0));
        adc_sync = 1'b1;
        tick();

        // Asynchronous reset mid-burst
        sample(64'h0_00000001);
        chk("pre_rst_wvalid", 128'(m_fifo_wvalid), 128'(1));
        rst = 1'b0;
        #2;
        chk("arst_wvalid", 128'(m_fifo_wvalid), 128'(0));
        chk("arst_ovf", 128'(overflows), 128'(0));
        chk("arst_timer", 128'(rx_timer), 128'(0));
        chk("arst_addr", 128'(m_fifo_awaddr), 128'(0));
        chk("arst_dvalid", 128'(m_descr_valid), 128'(0));
        tick();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fe_simple_rx_burst.md
Name: fe_simple_rx_burst

Overview:
- RX-side counterpart of the simple TX frontend.
- Takes a continuous ADC sample stream, timestamps it with a local RX sample timer, and packs it into fixed-size bursts.
- Writes each burst into the ring-buffer RAM through a word write port, then emits one descriptor per burst toward the DMA engine.
- The descriptor layout matches the TX descriptor: {timestamp, samples-1, words-1}.

Parameters:
- TIMESTAMP_BITS, 48: width of the RX sample timer and of the descriptor timestamp.
- RAM_ADDR_WIDTH, 18: byte address width of the ring RAM.
- DATA_BITS, 3: log2 of bytes per RAM word. Fixed at 3 (64-bit word); other values are unsupported.
- DATA_WIDTH, 64: equals 8 << DATA_BITS.
- SAMPLES_WIDTH, 17: width of the samples-1 field and of cfg_burst_samples.
- WORD_ADDR_WIDTH, RAM_ADDR_WIDTH-DATA_BITS: width of word addresses and of the words-1 field.
- DESCR_WIDTH, TIMESTAMP_BITS+SAMPLES_WIDTH+WORD_ADDR_WIDTH: descriptor width.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous and active-low; clears all state.
- adc_data  in  64  sample slot. [31:0] carries chan0 I/Q ci16; [63:32] carries chan1.
- adc_valid  in  1  one sample per high cycle; cannot be stalled.
- adc_sync  in  1  when low, clears the RX timer and holds the block idle.
- cfg_enable  in  1  allows new bursts to start.
- cfg_format  in  1  0 = one channel (2 samples/word); 1 = two channels (1 sample/word).
- cfg_swap  in  1  format 1 only: swap the 32-bit halves.
- cfg_burst_samples  in  SAMPLES_WIDTH  N-1, where N is samples per burst.
- ram_rd_ptr  in  WORD_ADDR_WIDTH  consumer word pointer; the writer must not pass it.
- m_fifo_awaddr  out  WORD_ADDR_WIDTH  word write address.
- m_fifo_wdata  out  64  write data.
- m_fifo_wvalid  out  1  write request.
- m_fifo_wready  in  1  write accept.
- m_descr_valid  out  1  descriptor valid.
- m_descr_ready  in  1  descriptor accept.
- m_descr_data  out  DESCR_WIDTH  {ts, N-1, W-1}; ts in the MSBs, words-1 in the LSBs.
- rx_timer  out  TIMESTAMP_BITS  current RX sample time.
- overflows  out  32  count of dropped bursts; wraps.
- sig_overflow  out  1  one-cycle pulse per dropped burst.

Behaviour:
- Reset values: all outputs 0; wr_ptr 0; state IDLE.
- Timer: cleared while adc_sync is low; otherwise increments on each adc_valid.
- Burst timestamp: the timer value sampled with the burst's first adc_valid, before that increment.
- Word count: W = cfg_format ? N : ceil(N/2). Config is latched at burst start; changes mid-burst have no effect.
- Format 0 packing: first sample goes in [31:0], second in [63:32]. For odd N, the last word has [63:32] = 0.
- Format 1 packing: one word per sample; halves swapped when cfg_swap is set.
- States:
  - IDLE: wait for cfg_enable && adc_sync && adc_valid.
  - BURST: collect samples and write words.
  - DROP: discard the remainder of the burst.
  - DESCR: wait for the last word write and for descriptor acceptance.
- Burst start, evaluated on the starting sample:
  - free = ram_rd_ptr - wr_ptr - 1, mod 2^WORD_ADDR_WIDTH.
  - Go to DROP if free < W or m_descr_valid is still pending; this counts as an overflow.
  - Otherwise go to BURST with burst_base = wr_ptr.
- Word writes:
  - m_fifo_wvalid rises the cycle after the sample that completes a word.
  - wr_ptr advances on each wvalid&&wready handshake.
  - Only one word may be outstanding.
- Overflow in BURST: a word completes while the previous one is still unaccepted.
  - Drop wvalid and rewind wr_ptr to burst_base.
  - Enter DROP; pulse sig_overflow and increment overflows.
- DROP: consume the remaining samples of the burst's N, then return to IDLE-start logic.
- Descriptor: m_descr_valid rises the cycle after the last word handshake, and holds stable until ready.
- Back-to-back: after the last sample, the next adc_valid may start a new burst immediately if start conditions hold. Its words may be written while DESCR is still waiting.
- cfg_enable deasserted mid-burst: the current burst completes normally.
- adc_sync low mid-burst: abort the burst, rewind wr_ptr, count as overflow, go to IDLE.
- Wrap-around: wr_ptr wraps modulo 2^WORD_ADDR_WIDTH.
- Reset mid-operation: everything returns to reset values immediately; no descriptor is emitted.

Test Plan:
- Format 0, N=4, ram_rd_ptr=0 after reset, 4 valid samples A..D starting at timer=10, wready=1 → writes {B,A}@0 then {D,C}@1; descriptor ts=10, samples=3, words=1.
- Format 1, cfg_swap=1, N=2, adc_data=0x11112222_33334444 → wdata=0x33334444_11112222; words-1=1.
- Format 0, N=3 → last word upper half 0; words-1=1; wr_ptr advances by 2.
- free=1 with N=8 format 1 → no writes; overflows=1; one sig_overflow pulse; the next burst starts after 8 dropped samples.
- Hold wready=0 for 3 samples, format 1 → overflow on the 2nd sample, wr_ptr rewound to base; no descriptor.
- Hold m_descr_ready=0 over the next burst start → that burst is dropped and overflows increments; release ready → the held descriptor is accepted unchanged.
